// File: rtl/img_pkg.sv
// Shared pixel and writer-state types for the image write-back path.
package img_pkg;

  localparam int PIX_W = 8;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wr_state_t;

endpackage

// File: rtl/pix_fifo.sv
// Small synchronous FIFO holding packed RGB pixels between the filter and the BRAM writer.
// Occupancy is a registered count, so full/empty only reflect completed pushes and pops.
module pix_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/rgb_bram_writer.sv
// Write-back end of the image pipeline: buffers filtered RGB pixels and writes one frame
// into three BRAM channels at addresses 0..NUM_PIXELS-1, then pulses frame_done.
module rgb_bram_writer #(
  parameter int PIX_W      = 8,
  parameter int ADDR_W     = 9,
  parameter int NUM_PIXELS = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_red,
  input  logic [PIX_W-1:0]  in_green,
  input  logic [PIX_W-1:0]  in_blue,
  input  logic              wr_grant,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [PIX_W-1:0]  bram_din_r,
  output logic [PIX_W-1:0]  bram_din_g,
  output logic [PIX_W-1:0]  bram_din_b,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W:0]   pixel_count,
  output logic              drop_err
);

  import img_pkg::*;

  localparam int DW = 3 * PIX_W;
  localparam logic [ADDR_W:0]   NUM_PIX_C = (ADDR_W + 1)'(NUM_PIXELS);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  wr_state_t         state_q, state_d;
  logic [ADDR_W:0]   accept_cnt_q, accept_cnt_d;
  logic [ADDR_W:0]   pixel_count_q, pixel_count_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     din_q, din_d;
  logic              we_q, we_d;
  logic              drop_err_q, drop_err_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0]     fifo_dout;
  logic              ready_int;

  // Ready looks only at registered state, so a same-cycle pop never frees a slot for a push.
  assign ready_int = (state_q == RUN) && !fifo_full && (accept_cnt_q < NUM_PIX_C);
  assign fifo_push = in_valid && ready_int;
  assign fifo_pop  = (state_q == RUN) && !fifo_empty && wr_grant;

  pix_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({in_red, in_green, in_blue}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    accept_cnt_d  = accept_cnt_q;
    pixel_count_d = pixel_count_q;
    wr_idx_d      = wr_idx_q;
    addr_d        = addr_q;
    din_d         = din_q;
    we_d          = 1'b0;
    drop_err_d    = drop_err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = RUN;
          accept_cnt_d  = '0;
          pixel_count_d = '0;
          wr_idx_d      = '0;
          drop_err_d    = 1'b0;
        end else if (in_valid) begin
          drop_err_d = 1'b1;
        end
      end
      RUN: begin
        // The strobe visible now is the last one of the frame.
        if (we_q && (pixel_count_q == NUM_PIX_C)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (in_valid) drop_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (fifo_push) accept_cnt_d = accept_cnt_q + CNT_ONE;

    // A pop becomes a write strobe on the next cycle; addr/din otherwise hold.
    if (fifo_pop) begin
      we_d          = 1'b1;
      addr_d        = wr_idx_q;
      din_d         = fifo_dout;
      wr_idx_d      = wr_idx_q + ADDR_ONE;
      pixel_count_d = pixel_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      accept_cnt_q  <= '0;
      pixel_count_q <= '0;
      wr_idx_q      <= '0;
      addr_q        <= '0;
      din_q         <= '0;
      we_q          <= 1'b0;
      drop_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      accept_cnt_q  <= accept_cnt_d;
      pixel_count_q <= pixel_count_d;
      wr_idx_q      <= wr_idx_d;
      addr_q        <= addr_d;
      din_q         <= din_d;
      we_q          <= we_d;
      drop_err_q    <= drop_err_d;
    end
  end

  assign in_ready    = ready_int;
  assign bram_en     = we_q;
  assign bram_we     = we_q;
  assign bram_addr   = addr_q;
  assign bram_din_r  = din_q[DW-1 -: PIX_W];
  assign bram_din_g  = din_q[2*PIX_W-1 -: PIX_W];
  assign bram_din_b  = din_q[PIX_W-1:0];
  assign busy        = (state_q == RUN);
  assign frame_done  = (state_q == DONE);
  assign pixel_count = pixel_count_q;
  assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_rgb_bram_writer.sv
// Self-checking bench for rgb_bram_writer: a frame-level model predicts every output each
// cycle, and directed frames exercise stalls, over-offering, drops, aborts and stray starts.
module tb_rgb_bram_writer;
  import img_pkg::*;

  localparam int NUM   = 256;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       wr_grant = 1'b1;
  logic [7:0] in_red = '0, in_green = '0, in_blue = '0;
  logic       in_ready, bram_en, bram_we, busy, frame_done, drop_err;
  logic [8:0] bram_addr;
  logic [7:0] bram_din_r, bram_din_g, bram_din_b;
  logic [9:0] pixel_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rgb_bram_writer #(
    .PIX_W(8), .ADDR_W(9), .NUM_PIXELS(NUM), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue), .wr_grant(wr_grant),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din_r(bram_din_r), .bram_din_g(bram_din_g), .bram_din_b(bram_din_b),
    .busy(busy), .frame_done(frame_done), .pixel_count(pixel_count), .drop_err(drop_err)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rgb_pixel_t pix(input int i);
    rgb_pixel_t p;
    logic [7:0] v;
    v   = i[7:0];
    p.r = v;
    p.g = 8'd255 - v;
    p.b = v ^ 8'hAA;
    return p;
  endfunction

  // Frame-level model: accepted pixels queue up and must come out in order at 0,1,2,...
  int          phase = 0;
  int          acc_seen = 0;
  int          wr_seen = 0;
  logic [23:0] exp_q[$];
  bit          drop_exp = 1'b0;
  bit          we_exp = 1'b0;
  bit          rst_prev = 1'b0;
  bit          model_on = 1'b0;
  logic [8:0]  last_addr = '0;
  logic [23:0] last_din = '0;
  logic [23:0] cap [NUM];

  always @(negedge clk) begin : model
    int occ;
    bit rdy_exp;
    bit next_we;
    logic [23:0] px;
    if (model_on) begin
      if (rst_prev) begin
        checkOutput("reset_outputs", {in_ready, bram_en, bram_we, bram_addr, bram_din_r, bram_din_g,
                    bram_din_b, busy, frame_done, pixel_count, drop_err}, 64'd0);
        phase = 0; acc_seen = 0; wr_seen = 0; exp_q.delete();
        drop_exp = 1'b0; we_exp = 1'b0; last_addr = '0; last_din = '0;
      end else begin
        checkOutput("frame_done", frame_done, phase == 2);
        checkOutput("busy", busy, phase == 1);
        checkOutput("drop_err", drop_err, drop_exp);
        checkOutput("bram_we", bram_we, we_exp);
        checkOutput("bram_en", bram_en, we_exp);
        if (we_exp) begin
          checkOutput("write_has_pixel", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            px = exp_q.pop_front();
            checkOutput("bram_addr", bram_addr, wr_seen[8:0]);
            checkOutput("bram_din", {bram_din_r, bram_din_g, bram_din_b}, px);
            if (wr_seen < NUM) cap[wr_seen] = {bram_din_r, bram_din_g, bram_din_b};
            last_addr = wr_seen[8:0];
            last_din  = px;
            wr_seen++;
          end
        end else begin
          checkOutput("addr_hold", bram_addr, last_addr);
          checkOutput("din_hold", {bram_din_r, bram_din_g, bram_din_b}, last_din);
        end
        checkOutput("pixel_count", pixel_count, wr_seen);
      end
      occ     = acc_seen - wr_seen;
      rdy_exp = (phase == 1) && (occ < DEPTH) && (acc_seen < NUM);
      if (!rst_prev) checkOutput("in_ready", in_ready, rdy_exp);
      next_we = (phase == 1) && (occ > 0) && wr_grant;
      if (rdy_exp && in_valid) begin
        exp_q.push_back({in_red, in_green, in_blue});
        acc_seen++;
      end
      case (phase)
        0: begin
          if (start) begin
            phase = 1; acc_seen = 0; wr_seen = 0; exp_q.delete(); drop_exp = 1'b0;
          end else if (in_valid) begin
            drop_exp = 1'b1;
          end
        end
        1: if (we_exp && wr_seen == NUM) phase = 2;
        default: begin
          phase = 0;
          if (in_valid) drop_exp = 1'b1;
        end
      endcase
      we_exp = next_we;
    end
    rst_prev = reset;
    if (reset) model_on = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input int idx, input bit g, input bit s, input bit r);
    rgb_pixel_t p;
    p        = pix(idx);
    in_valid = v;
    in_red   = p.r;
    in_green = p.g;
    in_blue  = p.b;
    wr_grant = g;
    start    = s;
    reset    = r;
  endtask

  // Pulses start, then streams pixels; optional grant stall, stray start, start in DONE, or abort.
  task automatic run_frame(input int n_offer, input int stall_at, input int stall_len,
                           input int restart_at, input bit start_in_done, input int abort_after,
                           output int acc, output int wrs, output int lat, output int dones);
    int cyc = 0;
    int first_push = -1;
    int first_wr = -1;
    bit fin = 1'b0;
    bit pulse_next = 1'b0;
    acc = 0; wrs = 0; lat = -1; dones = 0;
    applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0);
    tick();
    while (!fin && cyc < 2000) begin
      applyStimulus(acc < n_offer, acc, !(cyc >= stall_at && cyc < stall_at + stall_len),
                    (cyc == restart_at) || pulse_next, 1'b0);
      pulse_next = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (first_push < 0) first_push = cyc;
        acc++;
      end
      if (bram_we) begin
        if (first_wr < 0) first_wr = cyc;
        wrs++;
        if (start_in_done && pixel_count == 10'(NUM)) pulse_next = 1'b1;
      end
      if (frame_done) begin
        dones++;
        fin = 1'b1;
      end
      if (stall_len > 0 && cyc == stall_at + stall_len - 1) begin
        checkOutput("stall_in_ready", in_ready, 0);
        checkOutput("stall_no_write", bram_we, 0);
        checkOutput("stall_fifo_level", acc - wrs, DEPTH);
      end
      if (abort_after > 0 && wrs == abort_after) fin = 1'b1;
      cyc++;
      tick();
    end
    if (!fin) checkOutput("frame_timeout", 0, 1);
    if (first_push >= 0 && first_wr >= 0) lat = first_wr - first_push;
    if (abort_after > 0) begin
      applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      if (frame_done) dones++;
      tick();
      applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("abort_outputs_zero", {bram_we, bram_en, busy, frame_done, in_ready,
                  pixel_count, bram_addr}, 0);
      tick();
    end
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (frame_done) dones++;
      tick();
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int acc, wrs, lat, dones;
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b1);
    repeat (3) tick();
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reset_pixel_count", pixel_count, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_bram_we", bram_we, 0);
    tick();

    $display("[TB] in_valid before start");
    applyStimulus(1'b1, 7, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    @(negedge clk);
    checkOutput("t3_drop_set", drop_err, 1);
    checkOutput("t3_in_ready", in_ready, 0);
    checkOutput("t3_no_write", bram_we, 0);
    tick();
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
    tick();

    $display("[TB] back-to-back frame");
    run_frame(NUM, -1, 0, -1, 1'b0, 0, acc, wrs, lat, dones);
    @(negedge clk);
    checkOutput("t1_accepted", acc, 256);
    checkOutput("t1_writes", wrs, 256);
    checkOutput("t1_latency", lat, 2);
    checkOutput("t1_frame_done_pulses", dones, 1);
    checkOutput("t1_pixel_count", pixel_count, 256);
    checkOutput("t1_drop_cleared", drop_err, 0);
    checkOutput("t1_pixel5", cap[5], 24'h05FAAF);
    checkOutput("t1_pixel255", cap[255], 24'hFF0055);
    tick();

    $display("[TB] grant stall mid-frame");
    run_frame(NUM, 20, 10, -1, 1'b0, 0, acc, wrs, lat, dones);
    checkOutput("t2_writes", wrs, 256);
    checkOutput("t2_frame_done_pulses", dones, 1);

    $display("[TB] over-offer 260 pixels");
    run_frame(260, -1, 0, -1, 1'b0, 0, acc, wrs, lat, dones);
    @(negedge clk);
    checkOutput("t4_accepted", acc, 256);
    checkOutput("t4_writes", wrs, 256);
    checkOutput("t4_drop_after_done", drop_err, 1);
    tick();

    $display("[TB] reset after 100 writes");
    run_frame(NUM, -1, 0, -1, 1'b0, 100, acc, wrs, lat, dones);
    checkOutput("t5_writes_before_abort", wrs, 100);
    checkOutput("t5_no_frame_done", dones, 0);
    run_frame(NUM, -1, 0, -1, 1'b0, 0, acc, wrs, lat, dones);
    checkOutput("t5_restart_writes", wrs, 256);
    checkOutput("t5_restart_pixel0", cap[0], 24'h00FFAA);
    checkOutput("t5_restart_done", dones, 1);

    $display("[TB] start during RUN and DONE");
    run_frame(NUM, -1, 0, 50, 1'b1, 0, acc, wrs, lat, dones);
    @(negedge clk);
    checkOutput("t6_writes", wrs, 256);
    checkOutput("t6_frame_done_pulses", dones, 1);
    checkOutput("t6_idle_after", busy, 0);
    checkOutput("t6_pixel_count", pixel_count, 256);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
